reg_addr_demux_1x2: RTL and testbench

Buffered 1-to-2 demultiplexer for 5-bit register-address tokens. It is the distribution end of the 2:1 register-address select path in the datapath. A single producer presents an address plus a select bit, and the block steers that address to one of two consumer ports, each with its own 2-entry FIFO and valid/ready handshake. Producers can therefore issue back-to-back while either consumer stalls.

---
 rtl/reg_addr_demux_pkg.sv | 15 +
 rtl/demux_fifo2.sv | 98 +++++++++
 rtl/reg_addr_demux_1x2.sv | 87 ++++++++
 tb/tb_reg_addr_demux_1x2.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_addr_demux_pkg.sv
// Shared constants and FIFO occupancy encoding for the register-address demux.
// The optional accepted-token counters are enabled with DEMUX_CNT_EN.
package reg_addr_demux_pkg;

    localparam int DATA_W_DEF = 5;
    localparam int DEPTH      = 2;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry synchronous FIFO whose head is held in a register, so the
// consumer sees registered data and no same-cycle fall-through exists.
module demux_fifo2
    import reg_addr_demux_pkg::*;
#(
    parameter int W = DATA_W_DEF,
    parameter int N = DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    fifo_state_e  state_r;
    fifo_state_e  state_s;
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [W-1:0] mem_r [N];
    logic [W-1:0] head_r;
    logic [W-1:0] head_s;
    logic         do_push_s;
    logic         do_pop_s;

    assign full  = (state_r == FULL);
    assign empty = (state_r == EMPTY);
    assign head  = head_r;

    // Guarded handshakes, next occupancy and next registered head.
    always_comb begin
        do_push_s = push && (state_r != FULL);
        do_pop_s  = pop && (state_r != EMPTY);
        state_s   = state_r;
        head_s    = head_r;
        case (state_r)
            EMPTY: begin
                if (do_push_s) begin
                    state_s = ONE;
                    head_s  = push_data;
                end else begin
                    state_s = EMPTY;
                end
            end
            ONE: begin
                if (do_push_s && do_pop_s) begin
                    state_s = ONE;
                    head_s  = push_data;
                end else if (do_push_s) begin
                    state_s = FULL;
                end else if (do_pop_s) begin
                    state_s = EMPTY;
                end else begin
                    state_s = ONE;
                end
            end
            FULL: begin
                if (do_pop_s) begin
                    state_s = ONE;
                    head_s  = mem_r[rd_ptr_r ^ 1'b1];
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = EMPTY;
                head_s  = {W{1'b0}};
            end
        endcase
    end

    // Occupancy, pointers, storage and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= EMPTY;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            head_r   <= {W{1'b0}};
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            state_r <= state_s;
            head_r  <= head_s;
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r ^ 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r ^ 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_addr_demux_1x2.sv
// Buffered 1-to-2 register-address demux: steers each token to one of two
// 2-entry FIFOs. Define DEMUX_CNT_EN to add saturating per-port push counters.
module reg_addr_demux_1x2 #(
    parameter int DATA_W = reg_addr_demux_pkg::DATA_W_DEF,
    parameter int DEPTH  = reg_addr_demux_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [reg_addr_demux_pkg::CNT_W-1:0] cnt0,
    output logic [reg_addr_demux_pkg::CNT_W-1:0] cnt1
`endif
);

    import reg_addr_demux_pkg::*;

    logic full0_s;
    logic full1_s;
    logic empty0_s;
    logic empty1_s;
    logic push0_s;
    logic push1_s;

    // Readiness depends only on the selected FIFO's registered occupancy.
    assign in_ready   = in_sel ? !full1_s : !full0_s;
    assign push0_s    = in_valid && !in_sel && !full0_s;
    assign push1_s    = in_valid && in_sel && !full1_s;
    assign out0_valid = !empty0_s;
    assign out1_valid = !empty1_s;

    demux_fifo2 #(.W(DATA_W), .N(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0_s),
        .push_data (in_data),
        .pop       (out0_ready),
        .full      (full0_s),
        .empty     (empty0_s),
        .head      (out0_data)
    );

    demux_fifo2 #(.W(DATA_W), .N(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1_s),
        .push_data (in_data),
        .pop       (out1_ready),
        .full      (full1_s),
        .empty     (empty1_s),
        .head      (out1_data)
    );

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;

    // Saturating accepted-token counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (push0_s && (cnt0_r != {CNT_W{1'b1}})) begin
                cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (push1_s && (cnt1_r != {CNT_W{1'b1}})) begin
                cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_addr_demux_1x2.sv
// Self-checking bench for reg_addr_demux_1x2 against a queue-based model;
// counter checks are compiled in when DEMUX_CNT_EN is defined.
module tb_reg_addr_demux_1x2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  in_data = 5'd0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  out0_data;
    logic        out0_valid;
    logic        out0_ready = 1'b0;
    logic [4:0]  out1_data;
    logic        out1_valid;
    logic        out1_ready = 1'b0;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int checks = 0;
    int errors = 0;

    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [4:0] last0, last1;
    int         mcnt0, mcnt1;
    logic [4:0] dut_pop0[$];
    logic [4:0] dut_pop1[$];
    logic       seen_ready, exp_ready, last_acc;

    always #5 clk = ~clk;

    reg_addr_demux_1x2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

`ifndef DEMUX_CNT_EN
    assign cnt0 = 16'd0;
    assign cnt1 = 16'd0;
`endif

    task automatic clear_model();
        q0.delete(); q1.delete(); dut_pop0.delete(); dut_pop1.delete();
        last0 = 5'd0; last1 = 5'd0; mcnt0 = 0; mcnt1 = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, advance the model at posedge, return at negedge.
    task automatic drive_cycle(input logic v, input logic s, input logic [4:0] d,
                               input logic r0, input logic r1);
        bit acc, p0, p1;
        in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
        #1;
        seen_ready = in_ready;
        exp_ready  = s ? (q1.size() < 2) : (q0.size() < 2);
        acc = v && exp_ready;
        last_acc = acc;
        p0 = r0 && (q0.size() > 0);
        p1 = r1 && (q1.size() > 0);
        if (out0_valid && r0) dut_pop0.push_back(out0_data);
        if (out1_valid && r1) dut_pop1.push_back(out1_data);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (s) begin q1.push_back(d); if (mcnt1 < 65535) mcnt1++; end
            else   begin q0.push_back(d); if (mcnt0 < 65535) mcnt0++; end
        end
        if (q0.size() > 0) last0 = q0[0];
        if (q1.size() > 0) last1 = q1[0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b/%b want 0/0", out0_valid, out1_valid); end
        checks++; if (out0_data !== 5'd0 || out1_data !== 5'd0) begin errors++;
            $display("FAIL reset_data: got %0d/%0d want 0/0", out0_data, out1_data); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready); end
`ifdef DEMUX_CNT_EN
        checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin errors++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt0, cnt1); end
`endif
    endtask

    task automatic test_single_push();
        apply_reset();
        drive_cycle(1'b1, 1'b0, 5'd7, 1'b0, 1'b0);
        in_valid = 1'b0;
        checks++; if (out0_valid !== 1'b1 || out0_data !== 5'd7) begin errors++;
            $display("FAIL single_out0: got v=%b d=%0d want v=1 d=7", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin errors++;
            $display("FAIL single_out1_idle: got %b want 0", out1_valid); end
`ifdef DEMUX_CNT_EN
        checks++; if (cnt0 !== 16'd1 || cnt1 !== 16'd0) begin errors++;
            $display("FAIL single_cnt: got %0d/%0d want 1/0", cnt0, cnt1); end
`endif
    endtask

    task automatic test_stall();
        logic [4:0] expect_seq[3];
        expect_seq[0] = 5'd3; expect_seq[1] = 5'd4; expect_seq[2] = 5'd5;
        apply_reset();
        drive_cycle(1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        checks++; if (seen_ready !== 1'b0) begin errors++;
            $display("FAIL stall_ready_low: got %b want 0", seen_ready); end
        checks++; if (out1_data !== 5'd3) begin errors++;
            $display("FAIL stall_head_hold: got %0d want 3", out1_data); end
        drive_cycle(1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        checks++; if (seen_ready !== 1'b0) begin errors++;
            $display("FAIL stall_no_accept_on_pop: got %b want 0", seen_ready); end
        checks++; if (in_ready !== 1'b1 || out1_data !== 5'd4) begin errors++;
            $display("FAIL stall_after_pop: got rdy=%b d=%0d want rdy=1 d=4", in_ready, out1_data); end
        drive_cycle(1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
        checks++; if (dut_pop1.size() != 3) begin errors++;
            $display("FAIL stall_count: got %0d want 3", dut_pop1.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (dut_pop1[i] !== expect_seq[i]) begin errors++;
                $display("FAIL stall_order[%0d]: got %0d want %0d", i, dut_pop1[i], expect_seq[i]); end
        end
        checks++; if (out1_valid !== 1'b0 || out1_data !== 5'd5) begin errors++;
            $display("FAIL stall_empty_hold: got v=%b d=%0d want v=0 d=5", out1_valid, out1_data); end
    endtask

    task automatic test_alternate();
        logic [4:0] sent0[$];
        logic [4:0] sent1[$];
        logic [4:0] d;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            d = 5'($urandom_range(0, 31));
            if (i % 2 == 0) sent0.push_back(d); else sent1.push_back(d);
            drive_cycle(1'b1, 1'(i % 2), d, 1'b1, 1'b1);
            checks++; if (seen_ready !== 1'b1) begin errors++;
                $display("FAIL alt_ready[%0d]: got %b want 1", i, seen_ready); end
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        checks++; if (dut_pop0 != sent0 || dut_pop1 != sent1) begin errors++;
            $display("FAIL alt_order: got %p/%p want %p/%p", dut_pop0, dut_pop1, sent0, sent1); end
    endtask

    task automatic test_independence();
        apply_reset();
        drive_cycle(1'b1, 1'b0, 5'd10, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 5'd11, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
        checks++; if (seen_ready !== 1'b1) begin errors++;
            $display("FAIL indep_ready: got %b want 1", seen_ready); end
        checks++; if (out1_valid !== 1'b1 || out1_data !== 5'd12 || out0_data !== 5'd10) begin errors++;
            $display("FAIL indep_data: got v1=%b d1=%0d d0=%0d want 1/12/10", out1_valid, out1_data, out0_data); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        drive_cycle(1'b1, 1'b0, 5'd21, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 5'd22, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'd23, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'd24, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL midrst_full: got %b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== 5'd0 ||
                      out1_data !== 5'd0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_outputs: got v=%b%b d=%0d/%0d rdy=%b want 00 0/0 1",
                     out0_valid, out1_valid, out0_data, out1_data, in_ready); end
`ifdef DEMUX_CNT_EN
        checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin errors++;
            $display("FAIL midrst_cnt: got %0d/%0d want 0/0", cnt0, cnt1); end
`endif
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic pv, ps; logic [4:0] pd;
        int bad = 0;
        apply_reset();
        pv = 1'b0; ps = 1'b0; pd = 5'd0;
        for (int i = 0; i < 400; i++) begin
            if (!(pv && !last_acc)) begin
                pv = 1'($urandom_range(0, 3) != 0);
                ps = 1'($urandom_range(0, 1));
                pd = 5'($urandom_range(0, 31));
            end
            last_acc = 1'b0;
            drive_cycle(pv, ps, pd, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            checks++; if (seen_ready !== exp_ready) begin errors++; bad++;
                if (bad < 10) $display("FAIL rand_ready[%0d]: got %b want %b", i, seen_ready, exp_ready); end
            checks++; if (out0_valid !== (q0.size() > 0) || out0_data !== last0) begin errors++; bad++;
                if (bad < 10) $display("FAIL rand_out0[%0d]: got v=%b d=%0d want v=%b d=%0d",
                                       i, out0_valid, out0_data, q0.size() > 0, last0); end
            checks++; if (out1_valid !== (q1.size() > 0) || out1_data !== last1) begin errors++; bad++;
                if (bad < 10) $display("FAIL rand_out1[%0d]: got v=%b d=%0d want v=%b d=%0d",
                                       i, out1_valid, out1_data, q1.size() > 0, last1); end
`ifdef DEMUX_CNT_EN
            checks++; if (cnt0 !== 16'(mcnt0) || cnt1 !== 16'(mcnt1)) begin errors++; bad++;
                if (bad < 10) $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d",
                                       i, cnt0, cnt1, mcnt0, mcnt1); end
`endif
        end
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 65535; i++) drive_cycle(1'b1, 1'b0, 5'(i), 1'b1, 1'b0);
        checks++; if (cnt0 !== 16'hFFFF) begin errors++;
            $display("FAIL sat_reach: got %h want ffff", cnt0); end
        drive_cycle(1'b1, 1'b0, 5'd1, 1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
        checks++; if (cnt0 !== 16'hFFFF || cnt1 !== 16'd0) begin errors++;
            $display("FAIL sat_hold: got %h/%h want ffff/0000", cnt0, cnt1); end
    endtask
`endif

    initial begin
        clear_model();
        last_acc = 1'b0;
        test_reset();
        test_single_push();
        test_stall();
        test_alternate();
        test_independence();
        test_mid_reset();
        test_random();
`ifdef DEMUX_CNT_EN
        test_saturation();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
